sand_sweep_ctrl: RTL and testbench

- Frame-rate sequencer that walks the packed sand grid in cell RAM: 2-bit cells, 16 cells per 32-bit word.
- For each word pair (region row r, floor row r+1), it reads both words and drives them to the sand_update physics block, then writes the returned words back.
- Sweeps bottom-up, row ROWS-2 down to 0, column word 0 up to COLS_WORDS-1, so each grain falls at most one row per sweep.
- Sits between the cell RAM write port and sand_update; the VGA reader owns the other RAM port.

---
 rtl/sand_pkg.sv | 23 ++
 rtl/sand_sweep_ctrl_if.sv | 32 +++
 rtl/sand_sweep_addr_gen.sv | 49 ++++
 rtl/sand_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_sand_sweep_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sand_pkg.sv
// rtl/sand_pkg.sv - shared cell encodings, word geometry and sweep FSM states for the sand grid
package sand_pkg;

    typedef enum logic [1:0] {
        AIR     = 2'b00,
        SAND    = 2'b01,
        SAND_AM = 2'b10,
        WALL    = 2'b11
    } cell_t;

    localparam int CELLS_PER_WORD = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_F,
        RD_R,
        CAP,
        WR_F,
        WR_R,
        NEXT
    } sweep_state_t;

endpackage

// File: rtl/sand_sweep_ctrl_if.sv
// rtl/sand_sweep_ctrl_if.sv - cell RAM write-port and sand_update word bus seen by the sweep sequencer
interface sand_sweep_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       region;
    logic [31:0]       floor;
    logic              screenbegin;
    logic              screenend;
    logic              screenbottom;
    logic              spout;
    logic [31:0]       new_region;
    logic [31:0]       new_floor;

    // sequencer side
    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        output region, floor, screenbegin, screenend, screenbottom, spout,
        input  mem_rdata, new_region, new_floor
    );

    // RAM / physics side
    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        input  region, floor, screenbegin, screenend, screenbottom, spout,
        output mem_rdata, new_region, new_floor
    );
endinterface

// File: rtl/sand_sweep_addr_gen.sv
// rtl/sand_sweep_addr_gen.sv - row/column walker with incremental region and floor base addresses
module sand_sweep_addr_gen #(
    parameter int COLS_WORDS = 40,
    parameter int ROWS       = 480,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              advance,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] region_base,
    output logic [ADDR_W-1:0] floor_base,
    output logic              last_col,
    output logic              last_row
);
    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(COLS_WORDS - 1);
    localparam logic [ADDR_W-1:0] START_ROW  = ADDR_W'(ROWS - 2);
    localparam logic [ADDR_W-1:0] START_BASE = ADDR_W'((ROWS - 2) * COLS_WORDS);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS_WORDS);

    // Bottom-up walk; the base steps by one row so no multiplier is needed,
    // and the final advance reloads so the next sweep starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row         <= START_ROW;
            col         <= '0;
            region_base <= START_BASE;
        end else if (restart || (advance && last_col && last_row)) begin
            row         <= START_ROW;
            col         <= '0;
            region_base <= START_BASE;
        end else if (advance) begin
            if (!last_col) begin
                col <= col + ADDR_W'(1);
            end else begin
                col         <= '0;
                row         <= row - ADDR_W'(1);
                region_base <= region_base - ROW_STEP;
            end
        end
    end

    assign floor_base = region_base + ROW_STEP;
    assign last_col   = (col == LAST_COL);
    assign last_row   = (row == '0);

endmodule

// File: rtl/sand_sweep_ctrl.sv
// rtl/sand_sweep_ctrl.sv - per-frame sweep of the sand grid through sand_update; SAND_SWEEP_SKIP_AIR_EN skips all-air words
module sand_sweep_ctrl
    import sand_pkg::*;
#(
    parameter int COLS_WORDS = 40,
    parameter int ROWS       = 480,
    parameter int ADDR_W     = 15,
    parameter int SPOUT_WORD = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    sand_sweep_ctrl_if.master  bus
);
    localparam logic [ADDR_W-1:0] START_ROW = ADDR_W'(ROWS - 2);
    localparam logic [ADDR_W-1:0] SPOUT_COL = ADDR_W'(SPOUT_WORD);

    sweep_state_t      state, state_nxt;
    logic              restart, advance, finish;
    logic [ADDR_W-1:0] row, col, region_base, floor_base;
    logic              last_col, last_row;
    logic [31:0]       region_q, floor_q, nr_q;
    logic              spout_w;

    sand_sweep_addr_gen #(
        .COLS_WORDS (COLS_WORDS),
        .ROWS       (ROWS),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .advance     (advance),
        .row         (row),
        .col         (col),
        .region_base (region_base),
        .floor_base  (floor_base),
        .last_col    (last_col),
        .last_row    (last_row)
    );

    assign spout_w = (row == '0) && (col == SPOUT_COL);

`ifdef SAND_SWEEP_SKIP_AIR_EN
    logic skip_air;
    // Region word is arriving on mem_rdata in CAP; floor is already registered.
    assign skip_air = (floor_q == '0) && (bus.mem_rdata == '0) && !spout_w;
`endif

    // State register; async reset drops the strobes in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore strobes; writes of a word always finish before the next reads.
    always_comb begin
        state_nxt     = state;
        restart       = 1'b0;
        advance       = 1'b0;
        finish        = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = RD_F;
                end
            end
            RD_F: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = floor_base + col;
                state_nxt    = RD_R;
            end
            RD_R: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = region_base + col;
                state_nxt    = CAP;
            end
            CAP: begin
`ifdef SAND_SWEEP_SKIP_AIR_EN
                if (skip_air) begin
                    advance   = 1'b1;
                    finish    = last_col && last_row;
                    state_nxt = (last_col && last_row) ? IDLE : RD_F;
                end else begin
                    state_nxt = WR_F;
                end
`else
                state_nxt = WR_F;
`endif
            end
            WR_F: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = floor_base + col;
                bus.mem_wdata = bus.new_floor;
                state_nxt     = WR_R;
            end
            WR_R: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = region_base + col;
                bus.mem_wdata = nr_q;
                state_nxt     = NEXT;
            end
            NEXT: begin
                advance   = 1'b1;
                finish    = last_col && last_row;
                state_nxt = (last_col && last_row) ? IDLE : RD_F;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word registers toward sand_update, the held region result and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            region_q <= '0;
            floor_q  <= '0;
            nr_q     <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (state == RD_R) floor_q  <= bus.mem_rdata;
            if (state == CAP)  region_q <= bus.mem_rdata;
            if (state == WR_F) nr_q     <= bus.new_region;
        end
    end

    assign busy             = (state != IDLE);
    assign bus.region       = region_q;
    assign bus.floor        = floor_q;
    assign bus.screenbegin  = (col == '0);
    assign bus.screenend    = last_col;
    assign bus.screenbottom = (row == START_ROW);
    assign bus.spout        = spout_w;

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// tb/tb_sand_sweep_ctrl.sv - directed-vector bench for sand_sweep_ctrl on a 2x2-word grid
module tb_sand_sweep_ctrl;
    localparam int COLS_WORDS = 2;
    localparam int ROWS       = 2;
    localparam int ADDR_W     = 4;
`ifdef SAND_SWEEP_SKIP_AIR_EN
    localparam int SPOUT_WORD = 7;
`else
    localparam int SPOUT_WORD = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    sand_sweep_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

    sand_sweep_ctrl #(
        .COLS_WORDS (COLS_WORDS),
        .ROWS       (ROWS),
        .ADDR_W     (ADDR_W),
        .SPOUT_WORD (SPOUT_WORD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:15];
    logic [31:0] init_img [0:3];
    logic        do_init = 1'b0;
    logic [31:0] rdq;

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= (i < 4) ? init_img[i] : 32'h0;
        end else begin
            if (ifc.mem_wr) ram[ifc.mem_addr] <= ifc.mem_wdata;
        end
        if (ifc.mem_rd) rdq <= ram[ifc.mem_addr];
    end

    // Ideal physics: a SAND cell above an AIR cell drops one row.
    function automatic logic [63:0] fall(input logic [31:0] r, input logic [31:0] f);
        logic [31:0] nr, nf;
        nr = r;
        nf = f;
        for (int i = 0; i < 16; i++) begin
            if (r[2*i +: 2] == 2'b01 && f[2*i +: 2] == 2'b00) begin
                nr[2*i +: 2] = 2'b00;
                nf[2*i +: 2] = 2'b01;
            end
        end
        return {nr, nf};
    endfunction

    logic [63:0] phys;
    assign phys           = fall(ifc.region, ifc.floor);
    assign ifc.new_region = phys[63:32];
    assign ifc.new_floor  = phys[31:0];
    assign ifc.mem_rdata  = rdq;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          ev [0:15];
    logic [31:0] ev_data [0:15];
    logic [3:0]  ev_flags [0:15];
    int          n_ev, n_wr, done_cnt, done_cyc, busy_low, overlap, busy_at_done;

    task automatic run_sweep(input int restart_at);
        n_ev = 0; n_wr = 0; done_cnt = 0; done_cyc = -1; busy_low = 0; overlap = 0; busy_at_done = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (ifc.mem_rd && ifc.mem_wr) overlap++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = int'(busy);
                end
            end
            if (done_cyc < 0 && !busy) busy_low++;
            if ((ifc.mem_rd || ifc.mem_wr) && n_ev < 16) begin
                ev[n_ev]       = (ifc.mem_wr ? 256 : 0) + int'(ifc.mem_addr);
                ev_data[n_ev]  = ifc.mem_wdata;
                ev_flags[n_ev] = {ifc.screenbegin, ifc.screenend, ifc.screenbottom, ifc.spout};
                n_ev++;
            end
            if (ifc.mem_wr) n_wr++;
            start = (cyc == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic load_ram(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        init_img[0] = w0; init_img[1] = w1; init_img[2] = w2; init_img[3] = w3;
        do_init = 1'b1;
        @(negedge clk);
        do_init = 1'b0;
    endtask

    int exp_ev [0:7] = '{'h002, 'h000, 'h102, 'h100, 'h003, 'h001, 'h103, 'h101};
    logic [31:0] exp_wd [0:3] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_000D, 32'h0000_0004};

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_rd",    32'(ifc.mem_rd), 32'd0);
        check_eq("rst_wr",    32'(ifc.mem_wr), 32'd0);
        check_eq("rst_addr",  32'(ifc.mem_addr), 32'd0);
        check_eq("rst_wdata", ifc.mem_wdata, 32'd0);
        check_eq("rst_region", ifc.region, 32'd0);
        check_eq("rst_floor", ifc.floor, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef SAND_SWEEP_SKIP_AIR_EN
        load_ram(32'h0, 32'h0, 32'h0, 32'h0);
        run_sweep(-1);
        check_eq("skip_writes", 32'(n_wr), 32'd0);
        check_eq("skip_done_cyc", 32'(done_cyc), 32'(3 * (ROWS - 1) * COLS_WORDS));
        check_eq("skip_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("skip_n_ev", 32'(n_ev), 32'd4);
        check_eq("skip_ev0", 32'(ev[0]), 32'h002);
        check_eq("skip_ev1", 32'(ev[1]), 32'h000);
        check_eq("skip_ev2", 32'(ev[2]), 32'h003);
        check_eq("skip_ev3", 32'(ev[3]), 32'h001);
        check_eq("skip_busy_low", 32'(busy_low), 32'd0);
`else
        load_ram(32'h4000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_000C);
        run_sweep(-1);
        check_eq("s1_n_ev", 32'(n_ev), 32'd8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("s1_ev%0d", i), 32'(ev[i]), 32'(exp_ev[i]));
        check_eq("s1_wd_a2", ev_data[2], exp_wd[0]);
        check_eq("s1_wd_a0", ev_data[3], exp_wd[1]);
        check_eq("s1_wd_a3", ev_data[6], exp_wd[2]);
        check_eq("s1_wd_a1", ev_data[7], exp_wd[3]);
        check_eq("s1_flags_c0", 32'(ev_flags[2]), 32'hA);
        check_eq("s1_flags_c1", 32'(ev_flags[6]), 32'h7);
        check_eq("s1_done_cyc", 32'(done_cyc), 32'd12);
        check_eq("s1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("s1_busy_low", 32'(busy_low), 32'd0);
        check_eq("s1_busy_at_done", 32'(busy_at_done), 32'd0);
        check_eq("s1_overlap", 32'(overlap), 32'd0);

        run_sweep(5);
        check_eq("s2_n_ev", 32'(n_ev), 32'd8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("s2_ev%0d", i), 32'(ev[i]), 32'(exp_ev[i]));
        check_eq("s2_done_cyc", 32'(done_cyc), 32'd12);
        check_eq("s2_done_cnt", 32'(done_cnt), 32'd1);

        begin
            int seen;
            seen = 0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 10 && seen == 0; c++) begin
                if (ifc.mem_wr) seen = 1;
                else @(negedge clk);
            end
            check_eq("wrf_seen", 32'(seen), 32'd1);
            reset = 1'b1;
            #1;
            check_eq("mid_rst_wr", 32'(ifc.mem_wr), 32'd0);
            check_eq("mid_rst_busy", 32'(busy), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
        end
        run_sweep(-1);
        check_eq("post_rst_ev0", 32'(ev[0]), 32'((ROWS - 1) * COLS_WORDS));
        check_eq("post_rst_done_cnt", 32'(done_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
